cordic_log_sequencer: RTL and testbench

Issue/retire controller for the fixed-latency hyperbolic-CORDIC logarithm pipeline and its exponent delay line. Accepts IEEE-754 single-precision operands on a valid/ready handshake and splits them into mantissa/exponent issue fields. Tracks each in-flight operation's tag and exception class through a LAT-deep valid shift register, then captures the pipeline result into an output FIFO. Output space is credit-based, so the non-stallable pipeline never overflows the FIFO.

---
 rtl/cordic_log_sequencer_if.sv | 26 ++
 rtl/cordic_log_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_cordic_log_sequencer.sv | 391 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cordic_log_sequencer_if.sv
// Request/result handshake bundle for cordic_log_sequencer.
// master = producer/consumer side, slave = sequencer side.
interface cordic_log_sequencer_if #(
  parameter int DW = 32,
  parameter int TW = 4
);
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_data;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [TW-1:0] out_tag;
  logic [1:0]    out_exc;

  modport master (
    output in_valid, in_data, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_exc
  );

  modport slave (
    input  in_valid, in_data, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_exc
  );
endinterface

// File: rtl/cordic_log_sequencer.sv
// Issue/retire controller for a fixed-latency CORDIC log pipeline with a credit-guarded show-ahead result FIFO.
// Optional performance counters are enabled by defining CORDIC_PERF_CNT_EN.
module cordic_log_sequencer #(
  parameter int LAT        = 19,
  parameter int DW         = 32,
  parameter int TW         = 4,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 flush,
  cordic_log_sequencer_if.slave bus,
  output logic                 pipe_issue,
  output logic [22:0]          pipe_mantissa,
  output logic [7:0]           pipe_exponent,
  input  logic [DW-1:0]        pipe_result,
  output logic                 busy
`ifdef CORDIC_PERF_CNT_EN
  ,
  output logic [31:0]          perf_issued,
  output logic [31:0]          perf_stall,
  output logic [31:0]          perf_exc
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = DW + TW + 2;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_e;

  state_e         state_q, state_d;
  logic [LAT-1:0] vld_q, vld_d;
  logic [TW-1:0]  tag_q [LAT];
  logic [TW-1:0]  tag_d [LAT];
  logic [1:0]     exc_q [LAT];
  logic [1:0]     exc_d [LAT];
  logic [CW-1:0]  inflight_q, inflight_d;
  logic [CW-1:0]  fifo_count_q, fifo_count_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [EW-1:0]  mem_q [FIFO_DEPTH];

  logic [1:0]     in_exc;
  logic [CW:0]    credit_used;
  logic           accept, retire, push, pop;
  logic [DW-1:0]  push_data;
  logic [EW-1:0]  head;

  assign pipe_mantissa = bus.in_data[22:0];
  assign pipe_exponent = bus.in_data[30:23];

  // NOTE: every always_comb output gets a default before any branch, so no path can infer a latch.
  always_comb begin
    in_exc = 2'b00;
    if (bus.in_data[31] || (&bus.in_data[30:23])) in_exc = 2'b10;
    else if (bus.in_data[30:23] == 8'h00)         in_exc = 2'b01;
  end

  // Credits count both in-flight and buffered work so the non-stallable pipe can always push.
  assign credit_used  = {1'b0, inflight_q} + {1'b0, fifo_count_q};
  assign bus.in_ready = (state_q == RUN) && (credit_used < (CW+1)'(FIFO_DEPTH)) && !flush;
  assign accept       = bus.in_valid && bus.in_ready;
  assign pipe_issue   = accept;
  assign retire       = vld_q[LAT-1];
  assign push         = retire && !flush;
  assign bus.out_valid = (fifo_count_q != '0);
  assign pop          = bus.out_valid && bus.out_ready && !flush;
  assign busy         = (inflight_q != '0) || bus.out_valid;

  always_comb begin
    push_data = pipe_result;
    case (exc_q[LAT-1])
      2'b01:   push_data = DW'(32'hFF80_0000);
      2'b10:   push_data = DW'(32'h7FC0_0000);
      default: push_data = pipe_result;
    endcase
  end

  // Head is forced to zero when empty so the outputs sit at their reset value.
  assign head         = bus.out_valid ? mem_q[rd_ptr_q] : '0;
  assign bus.out_data = head[EW-1 -: DW];
  assign bus.out_tag  = head[2 +: TW];
  assign bus.out_exc  = head[1:0];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable)            state_d = RUN;
      RUN:     if (!enable)           state_d = DRAIN;
      DRAIN:   if (inflight_q == '0)  state_d = IDLE;
      default:                        state_d = IDLE;
    endcase

    vld_d    = {vld_q[LAT-2:0], accept};
    tag_d[0] = bus.in_tag;
    exc_d[0] = in_exc;
    for (int i = 1; i < LAT; i++) begin
      tag_d[i] = tag_q[i-1];
      exc_d[i] = exc_q[i-1];
    end

    inflight_d   = inflight_q + CW'(accept) - CW'(retire);
    fifo_count_d = fifo_count_q + CW'(push) - CW'(pop);
    wr_ptr_d     = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d     = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    // Flush wins over everything; a retire in the same cycle is dropped with the rest.
    if (flush) begin
      state_d      = IDLE;
      vld_d        = '0;
      inflight_d   = '0;
      fifo_count_d = '0;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      vld_q        <= '0;
      inflight_q   <= '0;
      fifo_count_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      vld_q        <= vld_d;
      inflight_q   <= inflight_d;
      fifo_count_q <= fifo_count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  // NOTE: payload shift stages and FIFO storage carry no reset; they are only ever read under a valid bit or non-zero count.
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
    exc_q <= exc_d;
    if (push) mem_q[wr_ptr_q] <= {push_data, tag_q[LAT-1], exc_q[LAT-1]};
  end

  a_no_push_when_full: assert property (
    @(posedge clk) disable iff (!rst_n) push |-> (fifo_count_q != CW'(FIFO_DEPTH))
  );

`ifdef CORDIC_PERF_CNT_EN
  logic [31:0] perf_issued_q, perf_issued_d;
  logic [31:0] perf_stall_q,  perf_stall_d;
  logic [31:0] perf_exc_q,    perf_exc_d;
  logic        stall;

  assign stall = (state_q == RUN) && bus.in_valid && !bus.in_ready;

  always_comb begin
    perf_issued_d = perf_issued_q;
    perf_stall_d  = perf_stall_q;
    perf_exc_d    = perf_exc_q;
    if (accept && (perf_issued_q != '1))                    perf_issued_d = perf_issued_q + 32'd1;
    if (stall && (perf_stall_q != '1))                      perf_stall_d  = perf_stall_q + 32'd1;
    if (accept && (in_exc != 2'b00) && (perf_exc_q != '1)) perf_exc_d    = perf_exc_q + 32'd1;
  end

  // Counters survive flush; only rst_n clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issued_q <= '0;
      perf_stall_q  <= '0;
      perf_exc_q    <= '0;
    end else begin
      perf_issued_q <= perf_issued_d;
      perf_stall_q  <= perf_stall_d;
      perf_exc_q    <= perf_exc_d;
    end
  end

  assign perf_issued = perf_issued_q;
  assign perf_stall  = perf_stall_q;
  assign perf_exc    = perf_exc_q;
`endif
endmodule

// File: tb/tb_cordic_log_sequencer.sv
// Self-checking bench for cordic_log_sequencer: queue-based model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_cordic_log_sequencer;
  localparam int LAT   = 19;
  localparam int DW    = 32;
  localparam int TW    = 4;
  localparam int DEPTH = 32;
  localparam logic [31:0] XK = 32'h1234_5678;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          flush = 1'b0;
  logic          pipe_issue;
  logic [22:0]   pipe_mantissa;
  logic [7:0]    pipe_exponent;
  logic [DW-1:0] pipe_result;
  logic          busy;
`ifdef CORDIC_PERF_CNT_EN
  logic [31:0]   perf_issued, perf_stall, perf_exc;
`endif

  cordic_log_sequencer_if #(.DW(DW), .TW(TW)) bus ();

  cordic_log_sequencer #(.LAT(LAT), .DW(DW), .TW(TW), .FIFO_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .flush         (flush),
    .bus           (bus.slave),
    .pipe_issue    (pipe_issue),
    .pipe_mantissa (pipe_mantissa),
    .pipe_exponent (pipe_exponent),
    .pipe_result   (pipe_result),
    .busy          (busy)
`ifdef CORDIC_PERF_CNT_EN
    ,
    .perf_issued   (perf_issued),
    .perf_stall    (perf_stall),
    .perf_exc      (perf_exc)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pipeline stand-in: result is a fixed function of the issued fields, valid for exactly one cycle.
  logic [31:0] stub_data [LAT];
  logic        stub_vld  [LAT];
  int unsigned stub_cyc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stub_cyc <= 0;
      for (int i = 0; i < LAT; i++) begin
        stub_vld[i]  <= 1'b0;
        stub_data[i] <= 32'h0;
      end
    end else begin
      stub_cyc <= stub_cyc + 1;
      for (int i = LAT-1; i > 0; i--) begin
        stub_vld[i]  <= stub_vld[i-1];
        stub_data[i] <= stub_data[i-1];
      end
      stub_vld[0]  <= pipe_issue;
      stub_data[0] <= {1'b0, pipe_exponent, pipe_mantissa} ^ XK;
    end
  end

  assign pipe_result = stub_vld[LAT-1] ? stub_data[LAT-1] : (32'hDEAD_0000 | {16'h0, stub_cyc[15:0]});

  // Reference model: pending operations with their retire cycle, and the buffered results.
  typedef struct {
    logic [31:0]   data;
    logic [TW-1:0] tag;
    logic [1:0]    exc;
    int unsigned   ret;
  } item_t;

  typedef enum {M_IDLE, M_RUN, M_DRAIN} mstate_e;

  item_t       pend_q[$];
  item_t       fifo_q[$];
  mstate_e     m_state = M_IDLE;
  int unsigned m_cyc = 0;
  logic        m_ready, m_acc;
  int          m_pend_n;
  item_t       m_item;

  function automatic logic [1:0] exc_of(input logic [31:0] d);
    if (d[31] || d[30:23] == 8'hFF) return 2'b10;
    if (d[30:23] == 8'h00)          return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [31:0] result_of(input logic [31:0] d);
    case (exc_of(d))
      2'b01:   return 32'hFF80_0000;
      2'b10:   return 32'h7FC0_0000;
      default: return {1'b0, d[30:0]} ^ XK;
    endcase
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      pend_q.delete();
      fifo_q.delete();
      m_state = M_IDLE;
      m_cyc   = 0;
    end else begin
      m_ready = (m_state == M_RUN) && ((pend_q.size() + fifo_q.size()) < DEPTH) && !flush;
      m_acc   = m_ready && bus.in_valid;
      check("in_ready",    bus.in_ready, m_ready);
      check("pipe_issue",  pipe_issue, m_acc);
      check("pipe_fields", {pipe_exponent, pipe_mantissa}, bus.in_data[30:0]);
      check("out_valid",   bus.out_valid, fifo_q.size() != 0);
      check("busy",        busy, (pend_q.size() + fifo_q.size()) != 0);
      if (fifo_q.size() != 0) begin
        check("out_data", bus.out_data, fifo_q[0].data);
        check("out_tag",  bus.out_tag,  fifo_q[0].tag);
        check("out_exc",  bus.out_exc,  fifo_q[0].exc);
      end
      m_pend_n = pend_q.size();
      if (flush) begin
        pend_q.delete();
        fifo_q.delete();
        m_state = M_IDLE;
      end else begin
        if (fifo_q.size() != 0 && bus.out_ready) void'(fifo_q.pop_front());
        if (pend_q.size() != 0 && pend_q[0].ret == m_cyc) fifo_q.push_back(pend_q.pop_front());
        if (m_acc) begin
          m_item.data = result_of(bus.in_data);
          m_item.tag  = bus.in_tag;
          m_item.exc  = exc_of(bus.in_data);
          m_item.ret  = m_cyc + LAT;
          pend_q.push_back(m_item);
        end
        case (m_state)
          M_IDLE:  if (enable)        m_state = M_RUN;
          M_RUN:   if (!enable)       m_state = M_DRAIN;
          M_DRAIN: if (m_pend_n == 0) m_state = M_IDLE;
          default: m_state = M_IDLE;
        endcase
      end
      m_cyc++;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input string name, input int budget);
    for (int n = 0; n < budget && busy; n++) step();
    #1;
    check(name, busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int acc, pops, late;
  logic [31:0] exp_dat [3];
  logic [1:0]  exp_exc [3];

  initial begin
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;

    // Reset values
    repeat (2) step();
    #1;
    check("rst_in_ready",   bus.in_ready, 1'b0);
    check("rst_out_valid",  bus.out_valid, 1'b0);
    check("rst_pipe_issue", pipe_issue, 1'b0);
    check("rst_busy",       busy, 1'b0);
    check("rst_out_data",   bus.out_data, 32'h0);
    check("rst_out_tag",    bus.out_tag, 4'h0);
    check("rst_out_exc",    bus.out_exc, 2'b00);
    bus.in_valid = 1'b0;
    rst_n  = 1'b1;
    enable = 1'b1;
    step();

    // Single operand: latency LAT+1 to out_valid
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h4000_0000;
    bus.in_tag   = 4'd3;
    #1;
    check("t1_issue",    pipe_issue, 1'b1);
    check("t1_exponent", pipe_exponent, 8'h80);
    step();
    bus.in_valid = 1'b0;
    repeat (18) step();
    #1;
    check("t1_stub_result", pipe_result, 32'h5234_5678);
    check("t1_not_yet",     bus.out_valid, 1'b0);
    step();
    #1;
    check("t1_out_valid", bus.out_valid, 1'b1);
    check("t1_out_tag",   bus.out_tag, 4'd3);
    check("t1_out_exc",   bus.out_exc, 2'b00);
    check("t1_out_data",  bus.out_data, 32'h5234_5678);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;

    // Back-to-back 40 accepts with a free-running consumer
    bus.out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h4000_0000 + i * 32'h0001_3579;
      bus.in_tag   = 4'(i);
      #1;
      check("t2_ready_held", bus.in_ready, 1'b1);
      step();
    end
    bus.in_valid = 1'b0;
    wait_idle("t2_idle", 100);

    // Credit exhaustion with a stalled consumer
    bus.out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 60; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h3F80_0000 | (acc << 4);
      bus.in_tag   = 4'(acc);
      #1;
      if (bus.in_ready) acc++;
      step();
    end
    #1;
    check("t3_accepts", acc, 32);
    check("t3_full",    bus.in_ready, 1'b0);
    bus.out_ready = 1'b1;
    #1;
    check("t3_no_bypass", bus.in_ready, 1'b0);
    step();
    bus.out_ready = 1'b0;
    bus.in_data   = 32'h3F80_0AA0;
    #1;
    check("t3_credit_back", bus.in_ready, 1'b1);
    step();
    #1;
    check("t3_full_again", bus.in_ready, 1'b0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    wait_idle("t3_idle", 200);

    // Exception classes
    bus.out_ready = 1'b0;
    exp_dat[0] = 32'hFF80_0000; exp_exc[0] = 2'b01;
    exp_dat[1] = 32'h7FC0_0000; exp_exc[1] = 2'b10;
    exp_dat[2] = 32'h7FC0_0000; exp_exc[2] = 2'b10;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = (i == 0) ? 32'h0000_0000 : (i == 1) ? 32'hBF80_0000 : 32'h7F80_0000;
      bus.in_tag   = 4'(i + 1);
      #1;
      check("t4_accept", bus.in_ready, 1'b1);
      step();
    end
    bus.in_valid = 1'b0;
    repeat (20) step();
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t4_valid", bus.out_valid, 1'b1);
      check("t4_exc",   bus.out_exc, exp_exc[i]);
      check("t4_data",  bus.out_data, exp_dat[i]);
      check("t4_tag",   bus.out_tag, 4'(i + 1));
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
    end
    wait_idle("t4_idle", 10);

    // Flush with 3 buffered and 5 in flight
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h4040_0000 + i;
      bus.in_tag   = 4'(i);
      #1;
      check("t5_accept_a", bus.in_ready, 1'b1);
      step();
    end
    bus.in_valid = 1'b0;
    repeat (19) step();
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h4080_0000 + i;
      bus.in_tag   = 4'(i + 4);
      #1;
      check("t5_accept_b", bus.in_ready, 1'b1);
      step();
    end
    #1;
    check("t5_buffered", bus.out_valid, 1'b1);
    flush = 1'b1;
    #1;
    check("t5_flush_ready", bus.in_ready, 1'b0);
    check("t5_flush_issue", pipe_issue, 1'b0);
    step();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("t5_out_valid", bus.out_valid, 1'b0);
    check("t5_busy",      busy, 1'b0);
    check("t5_idle",      bus.in_ready, 1'b0);
    late = 0;
    for (int i = 0; i < 25; i++) begin
      step();
      #1;
      if (bus.out_valid) late++;
    end
    check("t5_no_late_push", late, 0);

    // Enable dropped with 4 in flight
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h3FC0_0000 + (i << 12);
      bus.in_tag   = 4'(8 + i);
      step();
    end
    bus.in_valid = 1'b0;
    enable       = 1'b0;
    step();
    bus.in_valid = 1'b1;
    #1;
    check("t6_ready_off", bus.in_ready, 1'b0);
    pops = 0;
    for (int n = 0; n < 100 && busy; n++) begin
      if (bus.out_valid) pops++;
      step();
      #1;
    end
    check("t6_idle", busy, 1'b0);
    check("t6_pops", pops, 4);
    check("t6_ready_idle", bus.in_ready, 1'b0);
    bus.in_valid = 1'b0;

    // Asynchronous reset mid-run
    enable        = 1'b1;
    bus.out_ready = 1'b0;
    step();
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h4100_0000 + i;
      bus.in_tag   = 4'(i);
      step();
    end
    bus.in_valid = 1'b0;
    repeat (21) step();
    bus.in_valid = 1'b1;
    #1;
    check("t7_pre_valid", bus.out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t7_in_ready",   bus.in_ready, 1'b0);
    check("t7_out_valid",  bus.out_valid, 1'b0);
    check("t7_pipe_issue", pipe_issue, 1'b0);
    check("t7_busy",       busy, 1'b0);
    check("t7_out_data",   bus.out_data, 32'h0);
    check("t7_out_tag",    bus.out_tag, 4'h0);
    check("t7_out_exc",    bus.out_exc, 2'b00);
    step();
    bus.in_valid = 1'b0;
    enable       = 1'b0;
    rst_n        = 1'b1;
    repeat (2) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
